// File: rtl/arbiter_requester_agent_pkg.sv
// Shared definitions for the arbiter requester agent: one-hot state encoding,
// default parameter values and the grant-wait counter width.
package arb_agent_pkg;

    localparam int ST_IDLE = 0;
    localparam int ST_REQ  = 1;
    localparam int ST_XFER = 2;
    localparam int ST_END  = 3;
    localparam int ST_GAP  = 4;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_XFER = 5'b00100,
        S_END  = 5'b01000,
        S_GAP  = 5'b10000
    } state_e;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_GAP_CYC = 2;
    localparam int WAIT_W      = 16;

endpackage

// File: rtl/arbiter_requester_agent_if.sv
// Command, arbiter and bus signals of one requester agent; master is the agent side.
interface arbiter_requester_agent_if import arb_agent_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) ();
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [LEN_W-1:0]  i_cmd_len;
    logic              o_req;
    logic              i_grant;
    logic              o_end_access;
    logic              o_bus_valid;
    logic [ADDR_W-1:0] o_bus_addr;
    logic              i_bus_ready;
    logic              o_done;
    logic              o_timeout;
    logic              i_timeout_clr;

    modport master (
        input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_grant, i_bus_ready, i_timeout_clr,
        output o_cmd_ready, o_req, o_end_access, o_bus_valid, o_bus_addr, o_done, o_timeout
    );

    modport slave (
        output i_cmd_valid, i_cmd_addr, i_cmd_len, i_grant, i_bus_ready, i_timeout_clr,
        input  o_cmd_ready, o_req, o_end_access, o_bus_valid, o_bus_addr, o_done, o_timeout
    );
endinterface

// File: rtl/arbiter_requester_agent_watchdog.sv
// Grant-wait watchdog: saturating REQ-cycle counter with a sticky timeout flag
// whose set takes priority over clear.
module arb_req_watchdog import arb_agent_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_restart,
    input  logic i_clr,
    output logic o_timeout
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              to_q, to_d;
    logic              set;

    // Set fires only on the increment that reaches TIMEOUT, so a saturated
    // counter cannot keep overriding a clear.
    always_comb begin
        cnt_d = cnt_q;
        set   = 1'b0;
        if (i_restart) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
            set   = (cnt_d == WAIT_W'(TIMEOUT));
        end
        if (set)        to_d = 1'b1;
        else if (i_clr) to_d = 1'b0;
        else            to_d = to_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign o_timeout = to_q;
endmodule

// File: rtl/arbiter_requester_agent.sv
// Client-side agent for one strict-priority arbiter port: takes a command,
// requests the bus, runs an addressed burst and signals end of tenure.
module arbiter_requester_agent import arb_agent_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    arbiter_requester_agent_if.master  bus
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              req_seen_q;
    logic              accept;
    logic              beat_hs;

    assign accept  = state_q[ST_IDLE] & bus.i_cmd_valid;
    assign beat_hs = bus.o_bus_valid & bus.i_bus_ready;

    assign bus.o_cmd_ready  = state_q[ST_IDLE];
    assign bus.o_req        = state_q[ST_REQ] | state_q[ST_XFER];
    assign bus.o_end_access = state_q[ST_END];
    assign bus.o_done       = state_q[ST_END];
    assign bus.o_bus_valid  = state_q[ST_XFER] & bus.i_grant;
    assign bus.o_bus_addr   = addr_q + ADDR_W'(beat_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.i_cmd_addr;
                    len_d   = bus.i_cmd_len;
                    beat_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // req_seen_q masks a grant still asserted from the previous tenure.
                if (req_seen_q && bus.i_grant) state_d = S_XFER;
            end
            S_XFER: begin
                if (beat_hs) begin
                    if (beat_q == len_q) state_d = S_END;
                    else                 beat_d  = beat_q + 1'b1;
                end
            end
            S_END: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            req_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            req_seen_q <= state_q[ST_REQ];
        end
    end

    arb_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (state_q[ST_REQ]),
        .i_restart (accept),
        .i_clr     (bus.i_timeout_clr),
        .o_timeout (bus.o_timeout)
    );
endmodule

// File: tb/tb_arbiter_requester_agent.sv
// Bench for arbiter_requester_agent: per-cycle reference model plus directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_arbiter_requester_agent;
    localparam int AW  = 8;
    localparam int LW  = 4;
    localparam int TO  = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arbiter_requester_agent_if #(.ADDR_W(AW), .LEN_W(LW)) ifc ();

    arbiter_requester_agent #(
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TIMEOUT (TO),
        .GAP_CYC (GAP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (ifc.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: transaction-level view of one tenure
    bit m_busy, m_xfer, m_endc, m_to;
    int m_reqc, m_beat, m_gap, m_wait, m_len, m_addr;

    int hs_addr[$];
    int hs_cyc[$];
    int acc_cyc[$];
    int end_q[$];

    always @(negedge clk) begin
        bit e_rdy, e_val, set;
        if (!rst_n) begin
            m_busy = 0; m_xfer = 0; m_endc = 0; m_to = 0;
            m_reqc = 0; m_beat = 0; m_gap = 0; m_wait = 0; m_len = 0; m_addr = 0;
            chk("rst_cmd_ready", ifc.o_cmd_ready, 1);
            chk("rst_req", ifc.o_req, 0);
            chk("rst_bus_valid", ifc.o_bus_valid, 0);
            chk("rst_end_access", ifc.o_end_access, 0);
            chk("rst_done", ifc.o_done, 0);
            chk("rst_timeout", ifc.o_timeout, 0);
            chk("rst_bus_addr", ifc.o_bus_addr, 0);
        end else begin
            e_rdy = !m_busy && !m_endc && (m_gap == 0);
            e_val = m_xfer && ifc.i_grant;
            chk("cmd_ready", ifc.o_cmd_ready, e_rdy);
            chk("req", ifc.o_req, m_busy);
            chk("end_access", ifc.o_end_access, m_endc);
            chk("done", ifc.o_done, m_endc);
            chk("bus_valid", ifc.o_bus_valid, e_val);
            chk("timeout", ifc.o_timeout, m_to);
            if (e_val) chk("bus_addr", ifc.o_bus_addr, (m_addr + m_beat) % 256);

            if (ifc.o_bus_valid && ifc.i_bus_ready) begin
                hs_addr.push_back(int'(ifc.o_bus_addr));
                hs_cyc.push_back(cyc);
            end
            if (ifc.o_end_access) end_q.push_back(cyc);
            if (ifc.i_cmd_valid && ifc.o_cmd_ready) acc_cyc.push_back(cyc);

            set = 0;
            if (m_endc) begin
                m_endc = 0;
                m_gap  = GAP;
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (!m_busy) begin
                if (ifc.i_cmd_valid) begin
                    m_busy = 1; m_xfer = 0; m_reqc = 0; m_beat = 0; m_wait = 0;
                    m_addr = int'(ifc.i_cmd_addr);
                    m_len  = int'(ifc.i_cmd_len);
                end
            end else if (!m_xfer) begin
                if (m_reqc >= 1 && ifc.i_grant) m_xfer = 1;
                m_reqc++;
                if (m_wait < 65535) begin
                    m_wait++;
                    if (m_wait == TO) set = 1;
                end
            end else if (ifc.i_grant && ifc.i_bus_ready) begin
                if (m_beat == m_len) begin
                    m_busy = 0; m_xfer = 0; m_endc = 1;
                end else begin
                    m_beat++;
                end
            end
            if (set)                    m_to = 1;
            else if (ifc.i_timeout_clr) m_to = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_addr.delete(); hs_cyc.delete(); acc_cyc.delete(); end_q.delete();
    endtask

    // Offers a command until accepted; returns in the first cycle after accept.
    task automatic send(input int addr, input int len);
        ifc.i_cmd_valid = 1'b1;
        ifc.i_cmd_addr  = AW'(addr);
        ifc.i_cmd_len   = LW'(len);
        for (int unsigned i = 0; i < 20; i++) begin
            if (ifc.o_cmd_ready) begin
                step();
                ifc.i_cmd_valid = 1'b0;
                return;
            end
            step();
        end
        ifc.i_cmd_valid = 1'b0;
        chk("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_end(input string nm, input int unsigned max);
        for (int unsigned i = 0; i < max; i++) begin
            if (ifc.o_end_access) return;
            step();
        end
        chk(nm, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n_end;
        rst_n             = 1'b0;
        ifc.i_cmd_valid   = 1'b0;
        ifc.i_cmd_addr    = '0;
        ifc.i_cmd_len     = '0;
        ifc.i_grant       = 1'b0;
        ifc.i_bus_ready   = 1'b0;
        ifc.i_timeout_clr = 1'b0;
        repeat (3) step();
        chk("reset_ready_pin", ifc.o_cmd_ready, 1);
        chk("reset_req_pin", ifc.o_req, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single beat, grant 3 cycles after o_req
        clear_logs();
        ifc.i_bus_ready = 1'b1;
        send(8'h10, 0);
        chk("t1_req_after_accept", ifc.o_req, 1);
        repeat (3) step();
        ifc.i_grant = 1'b1;
        wait_end("t1_end_wait", 10);
        chk("t1_end_pulse", ifc.o_end_access, 1);
        chk("t1_done_pulse", ifc.o_done, 1);
        chk("t1_req_in_end", ifc.o_req, 0);
        chk("t1_valid_in_end", ifc.o_bus_valid, 0);
        step();
        chk("t1_end_one_cycle", ifc.o_end_access, 0);
        chk("t1_ready_gap1", ifc.o_cmd_ready, 0);
        chk("t1_req_gap1", ifc.o_req, 0);
        chk("t1_beats", hs_addr.size(), 1);
        if (hs_addr.size() == 1) begin
            chk("t1_addr", hs_addr[0], 8'h10);
            chk("t1_beat_lat", hs_cyc[0] - acc_cyc[0], 5);
        end
        if (end_q.size() == 1) chk("t1_end_lat", end_q[0] - acc_cyc[0], 6);
        else chk("t1_end_count", end_q.size(), 1);
        step();
        chk("t1_ready_gap2", ifc.o_cmd_ready, 0);
        chk("t1_req_gap2", ifc.o_req, 0);
        step();
        chk("t1_ready_back", ifc.o_cmd_ready, 1);
        ifc.i_grant = 1'b0;

        // Wrapping burst with toggling ready
        clear_logs();
        ifc.i_grant = 1'b1;
        send(8'hFE, 3);
        ifc.i_bus_ready = 1'b1;
        for (int unsigned i = 0; i < 40; i++) begin
            if (ifc.o_end_access) break;
            step();
            ifc.i_bus_ready = ~ifc.i_bus_ready;
        end
        step();
        chk("t2_beats", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            chk("t2_addr0", hs_addr[0], 8'hFE);
            chk("t2_addr1", hs_addr[1], 8'hFF);
            chk("t2_addr2", hs_addr[2], 8'h00);
            chk("t2_addr3", hs_addr[3], 8'h01);
            if (end_q.size() == 1) chk("t2_end_lat", end_q[0] - hs_cyc[3], 1);
        end
        chk("t2_end_count", end_q.size(), 1);
        ifc.i_bus_ready = 1'b1;
        ifc.i_grant     = 1'b0;

        // Timeout after 8 REQ cycles, then burst completes
        clear_logs();
        send(8'h20, 1);
        for (int unsigned i = 1; i <= 8; i++) begin
            chk("t3_to_before", ifc.o_timeout, 0);
            step();
        end
        chk("t3_to_set", ifc.o_timeout, 1);
        repeat (3) step();
        ifc.i_grant = 1'b1;
        wait_end("t3_end_wait", 10);
        step();
        chk("t3_beats", hs_addr.size(), 2);
        if (hs_addr.size() == 2) chk("t3_addr1", hs_addr[1], 8'h21);
        chk("t3_to_sticky", ifc.o_timeout, 1);
        ifc.i_timeout_clr = 1'b1;
        step();
        ifc.i_timeout_clr = 1'b0;
        chk("t3_to_cleared", ifc.o_timeout, 0);
        ifc.i_grant = 1'b0;

        // Clear coincident with set: set wins
        ifc.i_timeout_clr = 1'b1;
        send(8'h24, 0);
        repeat (8) step();
        ifc.i_timeout_clr = 1'b0;
        chk("t3_set_over_clr", ifc.o_timeout, 1);
        ifc.i_grant = 1'b1;
        wait_end("t3b_end_wait", 10);
        ifc.i_timeout_clr = 1'b1;
        step();
        ifc.i_timeout_clr = 1'b0;
        chk("t3b_to_cleared", ifc.o_timeout, 0);

        // Grant drop mid-burst
        clear_logs();
        send(8'h30, 3);
        repeat (2) step();
        chk("t4_first_valid", ifc.o_bus_valid, 1);
        step();
        step();
        ifc.i_grant = 1'b0;
        #1;
        chk("t4_valid_drop1", ifc.o_bus_valid, 0);
        step();
        chk("t4_valid_drop2", ifc.o_bus_valid, 0);
        step();
        ifc.i_grant = 1'b1;
        wait_end("t4_end_wait", 10);
        step();
        chk("t4_beats", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            chk("t4_addr2", hs_addr[2], 8'h32);
            chk("t4_addr3", hs_addr[3], 8'h33);
            chk("t4_resume_gap", hs_cyc[2] - hs_cyc[1], 3);
        end
        chk("t4_end_count", end_q.size(), 1);

        // Stale grant across back-to-back commands, valid held through GAP
        clear_logs();
        send(8'h50, 0);
        ifc.i_cmd_valid = 1'b1;
        ifc.i_cmd_addr  = 8'h60;
        ifc.i_cmd_len   = '0;
        wait_end("t5_end_wait", 10);
        for (int unsigned i = 0; i < 10; i++) begin
            step();
            if (acc_cyc.size() >= 2) break;
        end
        ifc.i_cmd_valid = 1'b0;
        wait_end("t5b_end_wait", 10);
        step();
        chk("t5_accepts", acc_cyc.size(), 2);
        chk("t5_beats", hs_addr.size(), 2);
        if (acc_cyc.size() == 2 && end_q.size() >= 1 && hs_addr.size() == 2) begin
            chk("t5_no_accept_in_gap", acc_cyc[1] - end_q[0], 3);
            chk("t5_stale_grant_ignored", hs_cyc[1] - acc_cyc[1], 3);
            chk("t5_addr", hs_addr[1], 8'h60);
        end

        // Reset mid-burst after the first beat
        clear_logs();
        send(8'h70, 3);
        repeat (2) step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req_rst", ifc.o_req, 0);
        chk("t6_valid_rst", ifc.o_bus_valid, 0);
        chk("t6_end_rst", ifc.o_end_access, 0);
        chk("t6_ready_rst", ifc.o_cmd_ready, 1);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        n_end = end_q.size();
        chk("t6_no_end_pulse", n_end, 0);
        clear_logs();
        send(8'h40, 0);
        wait_end("t6_end_wait", 10);
        step();
        chk("t6_beats", hs_addr.size(), 1);
        if (hs_addr.size() == 1) chk("t6_addr", hs_addr[0], 8'h40);

        // Randomized traffic against the model
        for (int unsigned i = 0; i < 600; i++) begin
            ifc.i_cmd_valid   = ($urandom_range(0, 2) == 0);
            ifc.i_cmd_addr    = AW'($urandom);
            ifc.i_cmd_len     = LW'($urandom_range(0, 5));
            ifc.i_grant       = ($urandom_range(0, 3) != 0);
            ifc.i_bus_ready   = ($urandom_range(0, 2) != 0);
            ifc.i_timeout_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        ifc.i_cmd_valid   = 1'b0;
        ifc.i_timeout_clr = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
